// File: rtl/bcd_modcnt.sv
// bcd_modcnt: modulo-MOD two-digit BCD counter for the clock datapath.
// One instance acts as a seconds, minutes or hours stage. It supports
// count-up cascade enable, manual up/down stepping, and a range-checked
// parallel load. CA is a combinational carry that feeds the next stage EN.
//
// Optional build macro: BCDCNT_H12_EN adds an H12 input and a PM output.
// With it, QH/QL can present the value in 12-hour form; the stored count
// itself stays in 24-hour form.
module bcd_modcnt #(
  parameter int MOD  = 24,
  parameter int HI_W = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic            INC,
  input  logic            DEC,
  input  logic            LD,
  input  logic [HI_W-1:0] LDH,
  input  logic [3:0]      LDL,
`ifdef BCDCNT_H12_EN
  input  logic            H12,
  output logic            PM,
`endif
  output logic [HI_W-1:0] QH,
  output logic [3:0]      QL,
  output logic            CA,
  output logic            LERR
);

  // Reject a modulus that the tens digit cannot represent.
  generate
    if (MOD < 2 || MOD > 10 * (2 ** HI_W)) begin : g_bad_mod
      $error("bcd_modcnt: MOD=%0d out of range for HI_W=%0d", MOD, HI_W);
    end
  endgenerate

  // Digits of the terminal count MOD-1.
  localparam logic [HI_W-1:0] MAX_H = HI_W'((MOD - 1) / 10);
  localparam logic [3:0]      MAX_L = 4'((MOD - 1) % 10);

  logic [HI_W-1:0] vh, vh_nxt;
  logic [3:0]      vl, vl_nxt;
  logic            lerr_nxt;
  logic            at_max, at_zero, up, down, load_ok;
  int              load_val;

  assign at_max  = (vh == MAX_H) && (vl == MAX_L);
  assign at_zero = (vh == '0) && (vl == 4'd0);
  assign up      = EN | INC;
  assign down    = DEC;

  // Only a cascade enable ever carries. Manual INC wrapping stays local so
  // that setting the hours does not bump the days.
  assign CA = RST & EN & ~LD & ~DEC & at_max;

  // Next count: load takes priority over stepping; up and down together hold.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    vh_nxt   = vh;
    vl_nxt   = vl;
    lerr_nxt = 1'b0;
    load_val = 10 * int'(LDH) + int'(LDL);
    load_ok  = (LDL <= 4'd9) && (load_val < MOD);
    if (LD) begin
      if (load_ok) begin
        vh_nxt = LDH;
        vl_nxt = LDL;
      end else begin
        lerr_nxt = 1'b1;
      end
    end else if (up && !down) begin
      if (at_max) begin
        vh_nxt = '0;
        vl_nxt = 4'd0;
      end else if (vl == 4'd9) begin
        vh_nxt = vh + HI_W'(1);
        vl_nxt = 4'd0;
      end else begin
        vl_nxt = vl + 4'd1;
      end
    end else if (down && !up) begin
      if (at_zero) begin
        vh_nxt = MAX_H;
        vl_nxt = MAX_L;
      end else if (vl == 4'd0) begin
        vh_nxt = vh - HI_W'(1);
        vl_nxt = 4'd9;
      end else begin
        vl_nxt = vl - 4'd1;
      end
    end
  end

  // Count and load-error registers, with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!RST) begin
      vh   <= '0;
      vl   <= 4'd0;
      LERR <= 1'b0;
    end else begin
      vh   <= vh_nxt;
      vl   <= vl_nxt;
      LERR <= lerr_nxt;
    end
  end

`ifdef BCDCNT_H12_EN
  logic [HI_W-1:0] disp_h;
  logic [3:0]      disp_l;
  logic            pm_nxt;
  int              nv;
  int              dv;

  // Display form of the next value: 0->12 and 13..23->1..11 when H12 is set.
  always_comb begin
    nv     = 10 * int'(vh_nxt) + int'(vl_nxt);
    dv     = nv;
    pm_nxt = (nv >= 12);
    if (H12) begin
      if (nv == 0)     dv = 12;
      else if (nv > 12) dv = nv - 12;
    end
    disp_h = HI_W'(dv / 10);
    disp_l = 4'(dv % 10);
  end

  // Registered display digits and PM flag; they follow H12 on the next edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      QH <= '0;
      QL <= 4'd0;
      PM <= 1'b0;
    end else begin
      QH <= disp_h;
      QL <= disp_l;
      PM <= pm_nxt;
    end
  end
`else
  // The digits are shown directly.
  assign QH = vh;
  assign QL = vl;
`endif

endmodule

// File: tb/tb_bcd_modcnt.sv
// Self-checking bench for bcd_modcnt: a MOD=24 instance and a MOD=60
// instance. The optional 12-hour display is exercised when BCDCNT_H12_EN
// is defined.
module tb_bcd_modcnt;

  logic       clk = 1'b0;
  logic       rst, en, inc, dec, ld;
  logic [1:0] ldh;
  logic [3:0] ldl;
  logic [1:0] qh;
  logic [3:0] ql;
  logic       ca, lerr;

  logic       en60, ld60, tie0;
  logic [2:0] ldh60;
  logic [3:0] ldl60;
  logic [2:0] qh60;
  logic [3:0] ql60;
  logic       ca60, lerr60;

`ifdef BCDCNT_H12_EN
  logic       h12, pm, pm60;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bcd_modcnt #(.MOD(24), .HI_W(2)) dut24 (
    .CLK(clk), .RST(rst), .EN(en), .INC(inc), .DEC(dec), .LD(ld),
    .LDH(ldh), .LDL(ldl),
`ifdef BCDCNT_H12_EN
    .H12(h12), .PM(pm),
`endif
    .QH(qh), .QL(ql), .CA(ca), .LERR(lerr)
  );

  bcd_modcnt #(.MOD(60), .HI_W(3)) dut60 (
    .CLK(clk), .RST(rst), .EN(en60), .INC(tie0), .DEC(tie0), .LD(ld60),
    .LDH(ldh60), .LDL(ldl60),
`ifdef BCDCNT_H12_EN
    .H12(tie0), .PM(pm60),
`endif
    .QH(qh60), .QL(ql60), .CA(ca60), .LERR(lerr60)
  );

  typedef struct {
    logic       en, inc, dec, ld;
    logic [1:0] ldh;
    logic [3:0] ldl;
    logic [1:0] eh;
    logic [3:0] el;
    logic       eca, elerr;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic a_en, input logic a_inc, input logic a_dec,
                              input logic a_ld, input logic [1:0] a_ldh,
                              input logic [3:0] a_ldl, input logic [1:0] a_eh,
                              input logic [3:0] a_el, input logic a_eca,
                              input logic a_elerr);
    vec_t v;
    v.en = a_en; v.inc = a_inc; v.dec = a_dec; v.ld = a_ld;
    v.ldh = a_ldh; v.ldl = a_ldl; v.eh = a_eh; v.el = a_el;
    v.eca = a_eca; v.elerr = a_elerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load24(input logic [1:0] h, input logic [3:0] l);
    ld = 1'b1; ldh = h; ldl = l; en = 1'b0; inc = 1'b0; dec = 1'b0;
    tick();
    ld = 1'b0;
  endtask

  initial begin
    int e;
    rst = 1'b0; en = 1'b1; inc = 1'b0; dec = 1'b0; ld = 1'b0;
    ldh = '0; ldl = '0; en60 = 1'b0; ld60 = 1'b0; ldh60 = '0; ldl60 = '0;
    tie0 = 1'b0;
`ifdef BCDCNT_H12_EN
    h12 = 1'b0;
`endif

    // Reset held two cycles with EN high.
    tick(); tick();
    check("reset qh", 32'(qh), 0);
    check("reset ql", 32'(ql), 0);
    check("reset lerr", 32'(lerr), 0);
    check("reset ca", 32'(ca), 0);
    check("reset qh60", 32'(qh60), 0);

    // Count a full cycle 00..23 and back to 00.
    rst = 1'b1;
    for (int i = 0; i < 24; i++) begin
      #1;
      check($sformatf("count ca v=%0d", i), 32'(ca), (i == 23) ? 1 : 0);
      tick();
      e = (i + 1) % 24;
      check($sformatf("count qh v=%0d", i), 32'(qh), e / 10);
      check($sformatf("count ql v=%0d", i), 32'(ql), e % 10);
    end

    //              en   inc  dec  ld   ldh  ldl    eh   el   ca   lerr
    vecs[0]  = mk(1'b0,1'b0,1'b1,1'b0,2'd0,4'd0, 2'd2,4'd3,1'b0,1'b0); // 00 dec -> 23
    vecs[1]  = mk(1'b0,1'b1,1'b0,1'b0,2'd0,4'd0, 2'd0,4'd0,1'b0,1'b0); // 23 inc -> 00 no carry
    vecs[2]  = mk(1'b0,1'b0,1'b0,1'b1,2'd1,4'd0, 2'd1,4'd0,1'b0,1'b0); // load 10
    vecs[3]  = mk(1'b0,1'b0,1'b1,1'b0,2'd0,4'd0, 2'd0,4'd9,1'b0,1'b0); // 10 dec -> 09
    vecs[4]  = mk(1'b0,1'b0,1'b0,1'b1,2'd1,4'd5, 2'd1,4'd5,1'b0,1'b0); // load 15
    vecs[5]  = mk(1'b1,1'b0,1'b1,1'b0,2'd0,4'd0, 2'd1,4'd5,1'b0,1'b0); // en&dec hold
    vecs[6]  = mk(1'b0,1'b0,1'b0,1'b1,2'd0,4'd8, 2'd0,4'd8,1'b0,1'b0); // load 08
    vecs[7]  = mk(1'b1,1'b1,1'b0,1'b0,2'd0,4'd0, 2'd0,4'd9,1'b0,1'b0); // en&inc single step
    vecs[8]  = mk(1'b1,1'b0,1'b0,1'b0,2'd0,4'd0, 2'd1,4'd0,1'b0,1'b0); // 09 -> 10
    vecs[9]  = mk(1'b0,1'b0,1'b0,1'b1,2'd1,4'd7, 2'd1,4'd7,1'b0,1'b0); // load 17
    vecs[10] = mk(1'b0,1'b0,1'b0,1'b1,2'd2,4'd5, 2'd1,4'd7,1'b0,1'b1); // 25 rejected
    vecs[11] = mk(1'b0,1'b0,1'b0,1'b0,2'd0,4'd0, 2'd1,4'd7,1'b0,1'b0); // lerr clears
    vecs[12] = mk(1'b0,1'b0,1'b0,1'b1,2'd0,4'd12,2'd1,4'd7,1'b0,1'b1); // ldl=12 rejected
    vecs[13] = mk(1'b1,1'b0,1'b0,1'b1,2'd3,4'd0, 2'd1,4'd7,1'b0,1'b1); // 30 rejected, en ignored
    vecs[14] = mk(1'b0,1'b0,1'b0,1'b1,2'd2,4'd3, 2'd2,4'd3,1'b0,1'b0); // load 23
    vecs[15] = mk(1'b1,1'b0,1'b0,1'b1,2'd0,4'd4, 2'd0,4'd4,1'b0,1'b0); // ld+en at 23
    vecs[16] = mk(1'b0,1'b0,1'b0,1'b1,2'd2,4'd3, 2'd2,4'd3,1'b0,1'b0); // load 23
    vecs[17] = mk(1'b1,1'b0,1'b1,1'b0,2'd0,4'd0, 2'd2,4'd3,1'b0,1'b0); // en&dec at 23
    vecs[18] = mk(1'b1,1'b1,1'b0,1'b0,2'd0,4'd0, 2'd0,4'd0,1'b1,1'b0); // en&inc at 23 carries
    vecs[19] = mk(1'b0,1'b0,1'b0,1'b1,2'd2,4'd3, 2'd2,4'd3,1'b0,1'b0); // load 23
    vecs[20] = mk(1'b1,1'b0,1'b0,1'b0,2'd0,4'd0, 2'd0,4'd0,1'b1,1'b0); // en wrap carries
    vecs[21] = mk(1'b0,1'b0,1'b1,1'b0,2'd0,4'd0, 2'd2,4'd3,1'b0,1'b0); // 00 dec -> 23

    for (int k = 0; k < 22; k++) begin
      en = vecs[k].en; inc = vecs[k].inc; dec = vecs[k].dec; ld = vecs[k].ld;
      ldh = vecs[k].ldh; ldl = vecs[k].ldl;
      #1;
      check($sformatf("vec%0d ca", k), 32'(ca), 32'(vecs[k].eca));
      tick();
      check($sformatf("vec%0d qh", k), 32'(qh), 32'(vecs[k].eh));
      check($sformatf("vec%0d ql", k), 32'(ql), 32'(vecs[k].el));
      check($sformatf("vec%0d lerr", k), 32'(lerr), 32'(vecs[k].elerr));
    end

    // Reset mid-run at the terminal count: CA is forced low, digits clear.
    rst = 1'b1;
    ld = 1'b0; en = 1'b1; inc = 1'b0; dec = 1'b0;
    rst = 1'b0;
    #1;
    check("rst ca at 23", 32'(ca), 0);
    tick();
    check("rst mid qh", 32'(qh), 0);
    check("rst mid ql", 32'(ql), 0);
    rst = 1'b1; en = 1'b0;

    // Sixty-count stage: 58, 59 (carry), 00; load range checks.
    ld60 = 1'b1; ldh60 = 3'd5; ldl60 = 4'd8;
    tick();
    ld60 = 1'b0; en60 = 1'b1;
    #1;
    check("m60 ca at 58", 32'(ca60), 0);
    tick();
    check("m60 qh 59", 32'(qh60), 5);
    check("m60 ql 59", 32'(ql60), 9);
    check("m60 ca at 59", 32'(ca60), 1);
    tick();
    check("m60 qh wrap", 32'(qh60), 0);
    check("m60 ql wrap", 32'(ql60), 0);
    en60 = 1'b0; ld60 = 1'b1; ldh60 = 3'd5; ldl60 = 4'd9;
    tick();
    check("m60 load59 qh", 32'(qh60), 5);
    check("m60 load59 ql", 32'(ql60), 9);
    check("m60 load59 lerr", 32'(lerr60), 0);
    ldh60 = 3'd6; ldl60 = 4'd0;
    tick();
    ld60 = 1'b0;
    check("m60 load60 qh", 32'(qh60), 5);
    check("m60 load60 ql", 32'(ql60), 9);
    check("m60 load60 lerr", 32'(lerr60), 1);

`ifdef BCDCNT_H12_EN
    // 12-hour display form.
    h12 = 1'b1;
    load24(2'd0, 4'd0);
    check("h12 v0 qh", 32'(qh), 1); check("h12 v0 ql", 32'(ql), 2); check("h12 v0 pm", 32'(pm), 0);
    load24(2'd1, 4'd1);
    check("h12 v11 qh", 32'(qh), 1); check("h12 v11 ql", 32'(ql), 1); check("h12 v11 pm", 32'(pm), 0);
    load24(2'd1, 4'd2);
    check("h12 v12 qh", 32'(qh), 1); check("h12 v12 ql", 32'(ql), 2); check("h12 v12 pm", 32'(pm), 1);
    load24(2'd1, 4'd3);
    check("h12 v13 qh", 32'(qh), 0); check("h12 v13 ql", 32'(ql), 1); check("h12 v13 pm", 32'(pm), 1);
    load24(2'd2, 4'd3);
    check("h12 v23 qh", 32'(qh), 1); check("h12 v23 ql", 32'(ql), 1); check("h12 v23 pm", 32'(pm), 1);
    load24(2'd1, 4'd3);
    h12 = 1'b0;
    tick();
    check("h24 v13 qh", 32'(qh), 1); check("h24 v13 ql", 32'(ql), 3); check("h24 v13 pm", 32'(pm), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
